// File: rtl/mem_bus_arbiter_pkg.sv
// ============================================================================
// Module   : mem_bus_arbiter_pkg
// Brief    : State and owner encodings shared by the RAM port arbiter files.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package mem_bus_arbiter_pkg;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_ACCESS = 2'd1;
    localparam logic [1:0] c_ST_RESP   = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE   = c_ST_IDLE,
        ST_ACCESS = c_ST_ACCESS,
        ST_RESP   = c_ST_RESP
    } state_t;

    // Which requester owns the transaction in flight.
    typedef enum logic {
        OWN_IF = 1'b0,
        OWN_LS = 1'b1
    } owner_t;

    localparam int c_CNT_W = 4;

endpackage

`default_nettype wire

// File: rtl/mem_bus_arbiter_select.sv
// ============================================================================
// Module   : mem_bus_arbiter_select
// Brief    : Grant decision between fetch and load/store. With MEM_ARB_FAIR_EN
//            defined, a starvation counter forces a waiting fetch through.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter_select
    import mem_bus_arbiter_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic   clk,
    input  logic   rst,
    input  logic   arb_en,
    input  logic   if_req,
    input  logic   ls_req,
    output logic   grant,
    output owner_t grant_owner
);

    assign grant = arb_en && (if_req || ls_req);

`ifdef MEM_ARB_FAIR_EN
    localparam int c_STARVE_W = $clog2(STARVE_LIMIT + 1);

    logic [c_STARVE_W-1:0] r_starve;
    logic                  w_force_if;

    assign w_force_if = (r_starve >= c_STARVE_W'(STARVE_LIMIT));

    always_comb begin
        grant_owner = OWN_IF;
        if (ls_req && !(if_req && w_force_if)) begin
            grant_owner = OWN_LS;
        end
    end

    // Only arbitrations the fetch side actually took part in move the counter.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_starve <= '0;
        end else if (arb_en && if_req) begin
            if (grant_owner == OWN_IF) begin
                r_starve <= '0;
            end else begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end
`else
    logic w_unused_clk_rst;

    assign w_unused_clk_rst = clk ^ rst;

    always_comb begin
        grant_owner = ls_req ? OWN_LS : OWN_IF;
    end
`endif

endmodule

`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
// ============================================================================
// Module   : mem_bus_arbiter
// Brief    : Shares one RAM port between instruction fetch and load/store,
//            one transaction at a time with WAIT_STATES extra RAM cycles.
//            Optional fair arbitration via MEM_ARB_FAIR_EN.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module mem_bus_arbiter
    import mem_bus_arbiter_pkg::*;
#(
    parameter int WAIT_STATES  = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        if_req,
    input  logic [31:0] if_addr,
    output logic        if_ack,
    output logic [31:0] if_rdata,
    input  logic        ls_req,
    input  logic        ls_we,
    input  logic [31:0] ls_addr,
    input  logic [31:0] ls_wdata,
    output logic        ls_ack,
    output logic [31:0] ls_rdata,
    output logic        ram_cs,
    output logic        ram_we,
    output logic        ram_oe,
    output logic [31:0] ram_addr,
    output logic [31:0] ram_data_in,
    input  logic [31:0] ram_data_out,
    output logic        busy
);

    state_t             r_state;
    state_t             w_state_nxt;
    logic [c_CNT_W-1:0] r_cnt;
    owner_t             r_owner;
    logic               r_we;

    logic               w_grant;
    owner_t             w_grant_owner;
    logic               w_load;
    logic               w_capture;
    logic               w_we_nxt;
    logic               w_access_nxt;

    mem_bus_arbiter_select #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_select (
        .clk         (clk),
        .rst         (rst),
        .arb_en      (r_state == ST_IDLE),
        .if_req      (if_req),
        .ls_req      (ls_req),
        .grant       (w_grant),
        .grant_owner (w_grant_owner)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_load      = 1'b0;
        w_capture   = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (w_grant) begin
                    w_state_nxt = ST_ACCESS;
                    w_load      = 1'b1;
                end
            end
            ST_ACCESS: begin
                if (r_cnt == '0) begin
                    w_state_nxt = ST_RESP;
                    w_capture   = 1'b1;
                end
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    // RAM strobes are registered from the next state so they line up with ACCESS.
    always_comb begin
        w_we_nxt     = r_we;
        w_access_nxt = (w_state_nxt == ST_ACCESS);
        if (w_load) begin
            w_we_nxt = (w_grant_owner == OWN_LS) && ls_we;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_owner     <= OWN_IF;
            r_we        <= 1'b0;
            ram_cs      <= 1'b0;
            ram_we      <= 1'b0;
            ram_oe      <= 1'b0;
            ram_addr    <= '0;
            ram_data_in <= '0;
            if_ack      <= 1'b0;
            ls_ack      <= 1'b0;
            if_rdata    <= '0;
            ls_rdata    <= '0;
            busy        <= 1'b0;
        end else begin
            r_state <= w_state_nxt;
            ram_cs  <= w_access_nxt;
            ram_we  <= w_access_nxt && w_we_nxt;
            ram_oe  <= w_access_nxt && !w_we_nxt;
            busy    <= (w_state_nxt != ST_IDLE);
            if_ack  <= w_capture && (r_owner == OWN_IF);
            ls_ack  <= w_capture && (r_owner == OWN_LS);

            if (w_load) begin
                r_owner     <= w_grant_owner;
                r_we        <= w_we_nxt;
                r_cnt       <= c_CNT_W'(WAIT_STATES);
                ram_addr    <= (w_grant_owner == OWN_LS) ? ls_addr : if_addr;
                ram_data_in <= w_we_nxt ? ls_wdata : 32'h0;
            end else if ((r_state == ST_ACCESS) && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end

            if (w_capture && !r_we) begin
                if (r_owner == OWN_IF) begin
                    if_rdata <= ram_data_out;
                end else begin
                    ls_rdata <= ram_data_out;
                end
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_mem_bus_arbiter.sv
// ============================================================================
// Module   : tb_mem_bus_arbiter
// Brief    : Self-checking bench for mem_bus_arbiter (WAIT_STATES=1 and 0
//            instances); honours MEM_ARB_FAIR_EN when defined.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
`default_nettype none

module tb_mem_bus_arbiter;

    localparam int WS    = 1;
    localparam int LIMIT = 4;
`ifdef MEM_ARB_FAIR_EN
    localparam bit c_FAIR = 1'b1;
`else
    localparam bit c_FAIR = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    logic        if_req = 1'b0, ls_req = 1'b0, ls_we = 1'b0;
    logic [31:0] if_addr = '0, ls_addr = '0, ls_wdata = '0;
    logic        if_ack, ls_ack, ram_cs, ram_we, ram_oe, busy;
    logic [31:0] if_rdata, ls_rdata, ram_addr, ram_data_in, ram_data_out;

    logic        b_if_req = 1'b0, b_ls_req = 1'b0, b_ls_we = 1'b0;
    logic [31:0] b_if_addr = '0, b_ls_addr = '0, b_ls_wdata = '0;
    logic        b_if_ack, b_ls_ack, b_ram_cs, b_ram_we, b_ram_oe, b_busy;
    logic [31:0] b_if_rdata, b_ls_rdata, b_ram_addr, b_ram_data_in, b_ram_data_out;

    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] ram_mem [256];
    logic [31:0] ref_mem [256];

    function automatic logic [31:0] init_word(input logic [7:0] idx);
        if (idx == 8'h40) return 32'hE3A00001;
        return 32'h5A00_0000 ^ ({24'd0, idx} * 32'h0001_0203);
    endfunction

    mem_bus_arbiter #(.WAIT_STATES(WS), .STARVE_LIMIT(LIMIT)) u_dut (
        .clk(clk), .rst(rst),
        .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
        .ls_req(ls_req), .ls_we(ls_we), .ls_addr(ls_addr), .ls_wdata(ls_wdata),
        .ls_ack(ls_ack), .ls_rdata(ls_rdata),
        .ram_cs(ram_cs), .ram_we(ram_we), .ram_oe(ram_oe), .ram_addr(ram_addr),
        .ram_data_in(ram_data_in), .ram_data_out(ram_data_out), .busy(busy)
    );

    mem_bus_arbiter #(.WAIT_STATES(0), .STARVE_LIMIT(LIMIT)) u_dut0 (
        .clk(clk), .rst(rst),
        .if_req(b_if_req), .if_addr(b_if_addr), .if_ack(b_if_ack), .if_rdata(b_if_rdata),
        .ls_req(b_ls_req), .ls_we(b_ls_we), .ls_addr(b_ls_addr), .ls_wdata(b_ls_wdata),
        .ls_ack(b_ls_ack), .ls_rdata(b_ls_rdata),
        .ram_cs(b_ram_cs), .ram_we(b_ram_we), .ram_oe(b_ram_oe), .ram_addr(b_ram_addr),
        .ram_data_in(b_ram_data_in), .ram_data_out(b_ram_data_out), .busy(b_busy)
    );

    // RAM behind the main instance; reloads its initial image while reset is low.
    always @(posedge clk) begin
        if (!rst) begin
            for (int i = 0; i < 256; i++) ram_mem[i] <= init_word(8'(i));
        end else if (ram_cs && ram_we) begin
            ram_mem[ram_addr[9:2]] <= ram_data_in;
        end
    end
    assign ram_data_out   = (ram_cs && ram_oe) ? ram_mem[ram_addr[9:2]] : 32'h0;
    assign b_ram_data_out = (b_ram_cs && b_ram_oe) ? init_word(b_ram_addr[9:2]) : 32'h0;

    task automatic ref_init();
        for (int i = 0; i < 256; i++) ref_mem[i] = init_word(8'(i));
    endtask

    task automatic apply_reset();
        rst = 1'b0;
        if_req = 1'b0;
        ls_req = 1'b0;
        b_ls_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        ref_init();
    endtask

    // Issues one request on one port and records what the RAM side and ack did.
    task automatic run_req(input logic port_ls, input logic we, input logic [31:0] addr,
                           input logic [31:0] wdata, output int ack_at, output int n_ack,
                           output int cs_cyc, output int we_cyc, output int oe_cyc,
                           output int addr_bad, output logic [31:0] last_din);
        ack_at = -1; n_ack = 0; cs_cyc = 0; we_cyc = 0; oe_cyc = 0; addr_bad = 0;
        last_din = '0;
        if (port_ls) begin
            ls_we = we; ls_addr = addr; ls_wdata = wdata; ls_req = 1'b1;
        end else begin
            if_addr = addr; if_req = 1'b1;
        end
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (ram_cs) begin
                cs_cyc++;
                if (ram_we) we_cyc++;
                if (ram_oe) oe_cyc++;
                if (ram_addr !== addr) addr_bad++;
                last_din = ram_data_in;
            end
            if (if_ack || ls_ack) begin
                n_ack++;
                if (ack_at < 0) ack_at = c;
                if (port_ls) ls_req = 1'b0;
                else if_req = 1'b0;
            end
        end
    endtask

    task automatic test_reset();
        rst = 1'b0;
        @(posedge clk);
        #1;
        n_cmp++;
        if ({if_ack, ls_ack, ram_cs, ram_we, ram_oe, busy} !== 6'b0) begin
            n_bad++;
            $display("FAIL reset_ctrl: got %b want 000000", {if_ack, ls_ack, ram_cs, ram_we, ram_oe, busy});
        end
        n_cmp++;
        if ({ram_addr, ram_data_in, if_rdata, ls_rdata} !== 128'h0) begin
            n_bad++;
            $display("FAIL reset_data: got %h %h %h %h want zeros", ram_addr, ram_data_in, if_rdata, ls_rdata);
        end
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        ref_init();
        repeat (3) @(posedge clk);
        #1;
        n_cmp++;
        if (busy !== 1'b0 || ram_cs !== 1'b0) begin
            n_bad++;
            $display("FAIL reset_idle: busy=%b cs=%b want 0 0", busy, ram_cs);
        end
    endtask

    task automatic test_fetch();
        int ack_at, n_ack, cs_cyc, we_cyc, oe_cyc, addr_bad;
        logic [31:0] din;
        apply_reset();
        run_req(1'b0, 1'b0, 32'h100, 32'h0, ack_at, n_ack, cs_cyc, we_cyc, oe_cyc, addr_bad, din);
        n_cmp++;
        if (cs_cyc != WS + 1 || oe_cyc != WS + 1 || we_cyc != 0) begin
            n_bad++;
            $display("FAIL fetch_ram: cs=%0d oe=%0d we=%0d want %0d %0d 0", cs_cyc, oe_cyc, we_cyc, WS + 1, WS + 1);
        end
        n_cmp++;
        if (ack_at != WS + 2 || n_ack != 1) begin
            n_bad++;
            $display("FAIL fetch_ack: at=%0d n=%0d want %0d 1", ack_at, n_ack, WS + 2);
        end
        n_cmp++;
        if (if_rdata !== 32'hE3A00001 || addr_bad != 0) begin
            n_bad++;
            $display("FAIL fetch_data: got %h addr_bad=%0d want e3a00001 0", if_rdata, addr_bad);
        end
    endtask

    task automatic test_store();
        int ack_at, n_ack, cs_cyc, we_cyc, oe_cyc, addr_bad;
        logic [31:0] din;
        apply_reset();
        run_req(1'b1, 1'b0, 32'h204, 32'h0, ack_at, n_ack, cs_cyc, we_cyc, oe_cyc, addr_bad, din);
        n_cmp++;
        if (ls_rdata !== init_word(8'h81) || din !== 32'h0) begin
            n_bad++;
            $display("FAIL load_data: got %h din=%h want %h 0", ls_rdata, din, init_word(8'h81));
        end
        run_req(1'b1, 1'b1, 32'h200, 32'hDEADBEEF, ack_at, n_ack, cs_cyc, we_cyc, oe_cyc, addr_bad, din);
        n_cmp++;
        if (we_cyc != WS + 1 || oe_cyc != 0 || din !== 32'hDEADBEEF || addr_bad != 0) begin
            n_bad++;
            $display("FAIL store_ram: we=%0d oe=%0d din=%h abad=%0d want %0d 0 deadbeef 0", we_cyc, oe_cyc, din, addr_bad, WS + 1);
        end
        n_cmp++;
        if (n_ack != 1 || ack_at != WS + 2 || ls_rdata !== init_word(8'h81)) begin
            n_bad++;
            $display("FAIL store_ack: n=%0d at=%0d rdata=%h want 1 %0d %h", n_ack, ack_at, ls_rdata, WS + 2, init_word(8'h81));
        end
        run_req(1'b1, 1'b0, 32'h200, 32'h0, ack_at, n_ack, cs_cyc, we_cyc, oe_cyc, addr_bad, din);
        n_cmp++;
        if (ls_rdata !== 32'hDEADBEEF) begin
            n_bad++;
            $display("FAIL store_readback: got %h want deadbeef", ls_rdata);
        end
    endtask

    task automatic test_collision();
        int ls_at = -1;
        int if_at = -1;
        apply_reset();
        if_addr = 32'h104; ls_addr = 32'h208; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        for (int c = 1; c <= 14; c++) begin
            @(posedge clk);
            #1;
            if (ls_ack) begin
                if (ls_at < 0) ls_at = c;
                ls_req = 1'b0;
            end
            if (if_ack) begin
                if (if_at < 0) if_at = c;
                if_req = 1'b0;
            end
        end
        n_cmp++;
        if (ls_at != WS + 2 || if_at != 2 * WS + 5) begin
            n_bad++;
            $display("FAIL collision_order: ls_at=%0d if_at=%0d want %0d %0d", ls_at, if_at, WS + 2, 2 * WS + 5);
        end
        n_cmp++;
        if (ls_rdata !== init_word(8'h82) || if_rdata !== init_word(8'h41)) begin
            n_bad++;
            $display("FAIL collision_data: ls=%h if=%h want %h %h", ls_rdata, if_rdata, init_word(8'h82), init_word(8'h41));
        end
    endtask

    task automatic test_starvation();
        int ls_n = 0;
        int if_n = 0;
        int ls_before_if = -1;
        apply_reset();
        if_addr = 32'h108; ls_addr = 32'h20C; ls_we = 1'b0;
        if_req = 1'b1; ls_req = 1'b1;
        for (int c = 1; c <= 10 * (WS + 3); c++) begin
            @(posedge clk);
            #1;
            if (ls_ack) ls_n++;
            if (if_ack) begin
                if_n++;
                if (ls_before_if < 0) ls_before_if = ls_n;
                if_req = 1'b0;
            end
        end
        ls_req = 1'b0;
`ifdef MEM_ARB_FAIR_EN
        n_cmp++;
        if (if_n != 1 || ls_before_if != LIMIT) begin
            n_bad++;
            $display("FAIL starve_fair: if_acks=%0d ls_before=%0d want 1 %0d", if_n, ls_before_if, LIMIT);
        end
        n_cmp++;
        if (ls_n != 9) begin
            n_bad++;
            $display("FAIL starve_fair_ls: ls_acks=%0d want 9", ls_n);
        end
`else
        n_cmp++;
        if (if_n != 0 || ls_n != 10) begin
            n_bad++;
            $display("FAIL starve_fixed: if_acks=%0d ls_acks=%0d want 0 10", if_n, ls_n);
        end
`endif
    endtask

    task automatic test_reset_mid();
        int ack_at, n_ack, cs_cyc, we_cyc, oe_cyc, addr_bad;
        int acks = 0;
        int busy_cyc = 0;
        logic [31:0] din;
        apply_reset();
        run_req(1'b0, 1'b0, 32'h100, 32'h0, ack_at, n_ack, cs_cyc, we_cyc, oe_cyc, addr_bad, din);
        ls_we = 1'b0; ls_addr = 32'h210; ls_req = 1'b1;
        @(posedge clk);
        #1;
        n_cmp++;
        if (ram_cs !== 1'b1 || if_rdata !== 32'hE3A00001) begin
            n_bad++;
            $display("FAIL midrst_pre: cs=%b if_rdata=%h want 1 e3a00001", ram_cs, if_rdata);
        end
        #2;
        rst = 1'b0;
        #1;
        n_cmp++;
        if ({ram_cs, ram_oe, busy, if_ack, ls_ack} !== 5'b0 || if_rdata !== 32'h0 || ls_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL midrst_clear: ctl=%b if=%h ls=%h want 0 0 0", {ram_cs, ram_oe, busy, if_ack, ls_ack}, if_rdata, ls_rdata);
        end
        ls_req = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b1;
        ref_init();
        for (int c = 1; c <= 6; c++) begin
            @(posedge clk);
            #1;
            if (if_ack || ls_ack) acks++;
            if (busy) busy_cyc++;
        end
        n_cmp++;
        if (acks != 0 || busy_cyc != 0) begin
            n_bad++;
            $display("FAIL midrst_after: acks=%0d busy_cycles=%0d want 0 0", acks, busy_cyc);
        end
    endtask

    // Transaction-level reference: one access at a time, each occupying WS+3 cycles.
    task automatic test_random();
        int          g = -100;
        int          free_at = 1;
        int          starve = 0;
        logic        a_ls = 1'b0, a_we = 1'b0, win_ls;
        logic [31:0] a_addr = '0, a_din = '0, a_data = '0;
        logic [31:0] exp_if = '0, exp_ls = '0;
        logic        e_cs, e_ack, e_busy;
        apply_reset();
        for (int k = 1; k <= 600; k++) begin
            if (!if_req && $urandom_range(0, 3) == 0) begin
                if_addr = {22'd0, 1'b0, 7'($urandom), 2'b00};
                if_req = 1'b1;
            end
            if (!ls_req && $urandom_range(0, 1) == 0) begin
                ls_addr = {22'd0, 1'b1, 7'($urandom_range(0, 15)), 2'b00};
                ls_we = 1'($urandom);
                ls_wdata = $urandom;
                ls_req = 1'b1;
            end
            if (k >= free_at && (if_req || ls_req)) begin
                win_ls = ls_req && !(c_FAIR && if_req && starve >= LIMIT);
                if (c_FAIR && if_req) starve = win_ls ? starve + 1 : 0;
                g = k;
                a_ls = win_ls;
                a_we = win_ls && ls_we;
                a_addr = win_ls ? ls_addr : if_addr;
                a_din = a_we ? ls_wdata : 32'h0;
                if (a_we) ref_mem[a_addr[9:2]] = ls_wdata;
                else a_data = ref_mem[a_addr[9:2]];
                free_at = k + WS + 3;
            end
            @(posedge clk);
            #1;
            e_cs = (k >= g) && (k <= g + WS);
            e_ack = (k == g + WS + 1);
            e_busy = (k >= g) && (k <= g + WS + 1);
            if (e_ack && !a_we) begin
                if (a_ls) exp_ls = a_data;
                else exp_if = a_data;
            end
            n_cmp++;
            if ({if_ack, ls_ack, ram_cs, busy} !== {e_ack && !a_ls, e_ack && a_ls, e_cs, e_busy}) begin
                n_bad++;
                $display("FAIL rand_ctl k=%0d: if_ack/ls_ack/cs/busy=%b want %b", k, {if_ack, ls_ack, ram_cs, busy},
                         {e_ack && !a_ls, e_ack && a_ls, e_cs, e_busy});
            end
            n_cmp++;
            if (if_rdata !== exp_if || ls_rdata !== exp_ls) begin
                n_bad++;
                $display("FAIL rand_rdata k=%0d: if=%h ls=%h want %h %h", k, if_rdata, ls_rdata, exp_if, exp_ls);
            end
            if (e_cs) begin
                n_cmp++;
                if ({ram_we, ram_oe, ram_addr, ram_data_in} !== {a_we, !a_we, a_addr, a_din}) begin
                    n_bad++;
                    $display("FAIL rand_ram k=%0d: we=%b oe=%b addr=%h din=%h want %b %b %h %h", k, ram_we, ram_oe,
                             ram_addr, ram_data_in, a_we, !a_we, a_addr, a_din);
                end
            end
            if (if_ack) if_req = 1'b0;
            if (ls_ack) ls_req = 1'b0;
        end
    endtask

    task automatic test_back_to_back();
        int          n = 0;
        int          ack_at [2] = '{-1, -1};
        int          bad_side = 0;
        logic [31:0] exp_addr = 32'h10;
        apply_reset();
        b_ls_addr = 32'h10;
        b_ls_req = 1'b1;
        for (int c = 1; c <= 10; c++) begin
            @(posedge clk);
            #1;
            if (b_if_ack || b_ram_we || b_ram_data_in !== 32'h0) bad_side++;
            if (b_ram_cs && b_ram_addr !== exp_addr) bad_side++;
            if (c == 3) begin
                n_cmp++;
                if (b_busy !== 1'b0) begin
                    n_bad++;
                    $display("FAIL b2b_idle_gap: busy=%b want 0", b_busy);
                end
            end
            if (b_ls_ack && n < 2) begin
                ack_at[n] = c;
                n_cmp++;
                if (b_ls_rdata !== init_word(exp_addr[9:2])) begin
                    n_bad++;
                    $display("FAIL b2b_data%0d: got %h want %h", n, b_ls_rdata, init_word(exp_addr[9:2]));
                end
                n++;
                if (n == 1) begin
                    exp_addr = 32'h14;
                    b_ls_addr = 32'h14;
                end else begin
                    b_ls_req = 1'b0;
                end
            end
        end
        n_cmp++;
        if (ack_at[0] != 2 || ack_at[1] != 5) begin
            n_bad++;
            $display("FAIL b2b_timing: acks at %0d,%0d want 2,5", ack_at[0], ack_at[1]);
        end
        n_cmp++;
        if (bad_side != 0 || b_if_rdata !== 32'h0) begin
            n_bad++;
            $display("FAIL b2b_side: bad_cycles=%0d if_rdata=%h want 0 0", bad_side, b_if_rdata);
        end
    endtask

    initial begin
        test_reset();
        test_fetch();
        test_store();
        test_collision();
        test_starvation();
        test_reset_mid();
        test_random();
        test_back_to_back();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire
